// File: rtl/main_mem_arb_pkg.sv
// Shared definitions for the main-memory arbiter: FSM encoding, requester IDs
// and the beat-counter width helper.
package main_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Ceiling log2; used to size the burst beat counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the last-served pointer is
// held by the parent. update qualifies the grant so it is only issued when the
// parent can accept a new owner.
module rr_arb2
  import main_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  input  logic       update,
  output logic [1:0] grant
);

  // On a tie the side that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (update) begin
      if (req == 2'b11) begin
        grant = (last_served == REQ_I) ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Arbitrates one single-port main memory between the I-side refill path and the
// D-side cache path. Reads are BLOCK_WORDS-beat aligned bursts, writes are a
// single unaligned word. Optional performance counters are enabled by defining
// MAIN_MEM_ARB_PERF_EN.
module main_mem_arbiter
  import main_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
`ifdef MAIN_MEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_i_grants,
  output logic [15:0]       perf_d_grants,
  output logic [15:0]       perf_conflicts
`endif
);

  localparam int unsigned BeatW = clog2(BLOCK_WORDS);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BLOCK_WORDS - 1);

  arb_state_e        state_q, state_d;
  logic              winner_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BeatW-1:0]  beat_q;
  logic              i_gnt_q, d_gnt_q;
  logic              i_rvalid_q, d_rvalid_q;
  logic              i_done_q, d_done_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic [1:0]        grant;

  rr_arb2 u_rr_arb2 (
    .req         ({d_req, i_req}),
    .last_served (last_q),
    .update      (state_q == IDLE),
    .grant       (grant)
  );

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) state_d = ACCESS;
      end
      ACCESS: begin
        if (mem_ready && (we_q || beat_q == LastBeat)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, request latch, beat counter and registered per-side outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      winner_q   <= REQ_I;
      last_q     <= REQ_D;  // so the I side wins the first tie
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      beat_q     <= '0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          beat_q <= '0;
          if (grant != 2'b00) begin
            winner_q <= grant[REQ_D];
            addr_q   <= grant[REQ_D] ? d_addr : i_addr;
            we_q     <= grant[REQ_D] & d_we;
            wdata_q  <= d_wdata;
            i_gnt_q  <= grant[REQ_I];
            d_gnt_q  <= grant[REQ_D];
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (!we_q) begin
              beat_q <= beat_q + 1'b1;
              if (winner_q == REQ_D) begin
                d_rdata_q  <= mem_rdata;
                d_rvalid_q <= 1'b1;
              end else begin
                i_rdata_q  <= mem_rdata;
                i_rvalid_q <= 1'b1;
              end
            end
            if (state_d == DONE) begin
              i_done_q <= (winner_q == REQ_I);
              d_done_q <= (winner_q == REQ_D);
            end
          end
        end
        DONE: begin
          i_gnt_q <= 1'b0;
          d_gnt_q <= 1'b0;
          last_q  <= winner_q;
        end
        default: ;
      endcase
    end
  end

  // Memory-side strobes; everything is zero outside ACCESS.
  always_comb begin
    mem_en    = (state_q == ACCESS);
    mem_we    = mem_en & we_q;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_en) begin
      mem_addr = we_q ? addr_q : {addr_q[ADDR_W-1:BeatW], beat_q};
      if (we_q) mem_wdata = wdata_q;
    end
  end

  assign i_gnt    = i_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_done   = i_done_q;
  assign d_done   = d_done_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != IDLE);

`ifdef MAIN_MEM_ARB_PERF_EN
  // Saturating grant and conflict counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else if (state_q == IDLE) begin
      if (grant[REQ_I] && perf_i_grants != 16'hFFFF) perf_i_grants <= perf_i_grants + 16'd1;
      if (grant[REQ_D] && perf_d_grants != 16'hFFFF) perf_d_grants <= perf_d_grants + 16'd1;
      if (i_req && d_req && perf_conflicts != 16'hFFFF) begin
        perf_conflicts <= perf_conflicts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the active edge.
module tb_main_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [9:0]  i_addr, d_addr;
  logic [31:0] d_wdata;
  logic        i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_en, mem_we, mem_ready, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef MAIN_MEM_ARB_PERF_EN
  logic [15:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

  int total = 0;
  int bad   = 0;

  // Memory model: ready after ready_lat cycles of mem_en; force_ready drives it regardless.
  int   ready_lat = 1;
  int   wcnt = 0;
  logic force_ready = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign mem_ready = force_ready | (mem_en && (wcnt == ready_lat - 1));
  assign mem_rdata = mem_en ? {16'hC0DE, 6'd0, mem_addr} : 32'h0;

  function automatic logic [31:0] model(input logic [9:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  main_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rdata   (i_rdata),
    .i_rvalid  (i_rvalid),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rdata   (d_rdata),
    .d_rvalid  (d_rvalid),
    .d_done    (d_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
`ifdef MAIN_MEM_ARB_PERF_EN
    ,
    .perf_i_grants  (perf_i_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  task automatic idle_inputs();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    i_addr = 10'h3FF; d_addr = 10'h3FF; d_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    total++;
    if ({i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_en, mem_we, busy} !== 9'h0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000000",
               {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_en, mem_we, busy});
    end
    total++;
    if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 106'h0) begin
      bad++;
      $display("FAIL reset_data got i_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h want all 0",
               i_rdata, d_rdata, mem_addr, mem_wdata);
    end
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_i_refill();
    ready_lat = 1;
    @(negedge clk);
    i_req = 1'b1; i_addr = 10'h040;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt, busy} !== 3'b101) begin
      bad++;
      $display("FAIL refill_gnt got {i_gnt,d_gnt,busy}=%b want=101", {i_gnt, d_gnt, busy});
    end
    i_req = 1'b0;  // dropping req must not cut the burst short
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if ({mem_en, mem_we, mem_addr} !== {2'b10, 10'h040 + 10'(k)}) begin
        bad++;
        $display("FAIL refill_addr beat=%0d got en=%b we=%b addr=%h want en=1 we=0 addr=%h",
                 k, mem_en, mem_we, mem_addr, 10'h040 + 10'(k));
      end
      if (k > 0) begin
        total++;
        if ({i_rvalid, i_done, i_rdata} !== {2'b10, model(10'h040 + 10'(k - 1))}) begin
          bad++;
          $display("FAIL refill_beat beat=%0d got rvalid=%b done=%b rdata=%h want 1 0 %h",
                   k - 1, i_rvalid, i_done, i_rdata, model(10'h040 + 10'(k - 1)));
        end
      end
    end
    @(negedge clk);
    total++;
    if ({i_rvalid, i_done, mem_en, i_rdata} !== {3'b110, model(10'h043)}) begin
      bad++;
      $display("FAIL refill_last got rvalid=%b done=%b en=%b rdata=%h want 1 1 0 %h",
               i_rvalid, i_done, mem_en, i_rdata, model(10'h043));
    end
    @(negedge clk);
    total++;
    if ({busy, i_gnt, i_done, i_rvalid} !== 4'b0000) begin
      bad++;
      $display("FAIL refill_end got {busy,gnt,done,rvalid}=%b want=0000",
               {busy, i_gnt, i_done, i_rvalid});
    end
  endtask

  task automatic test_ignore_ready();
    force_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, mem_en, i_done, d_done, i_rvalid, d_rvalid} !== 6'b0) begin
      bad++;
      $display("FAIL idle_ready got %b want 000000",
               {busy, mem_en, i_done, d_done, i_rvalid, d_rvalid});
    end
    force_ready = 1'b0;
  endtask

  task automatic test_tie();
    bit found;
    do_reset();
    ready_lat = 1;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 10'h080; d_addr = 10'h020;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL tie1_gnt got {i,d}=%b want=10", {i_gnt, d_gnt});
    end
    i_req = 1'b0; d_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (i_done) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL tie1_done got none want i_done"); end
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt, busy} !== 3'b000) begin
      bad++;
      $display("FAIL tie2_gap got {i,d,busy}=%b want=000", {i_gnt, d_gnt, busy});
    end
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL tie2_gnt got {i,d}=%b want=01", {i_gnt, d_gnt});
    end
    d_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_done) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL tie2_done got none want d_done"); end
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt} !== 2'b00) begin
      bad++;
      $display("FAIL pend_gap got {i,d}=%b want=00", {i_gnt, d_gnt});
    end
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL pend_gnt got {i,d}=%b want=10", {i_gnt, d_gnt});
    end
    i_req = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_write_wait();
    int en_cycles, dones, rvs, done_at;
    ready_lat = 3;
    en_cycles = 0; dones = 0; rvs = 0; done_at = -1;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h010; d_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        d_req = 1'b0;
        total++;
        if (d_gnt !== 1'b1) begin
          bad++;
          $display("FAIL wr_gnt got d_gnt=%b want=1", d_gnt);
        end
      end
      if (mem_en && mem_we && mem_addr == 10'h010 && mem_wdata == 32'hDEAD_BEEF) en_cycles++;
      if (d_done) begin dones++; done_at = c; end
      if (d_rvalid || i_rvalid) rvs++;
    end
    total++;
    if (en_cycles !== 3) begin
      bad++;
      $display("FAIL wr_strobe got cycles=%0d want=3", en_cycles);
    end
    total++;
    if (dones !== 1 || done_at !== 4) begin
      bad++;
      $display("FAIL wr_done got count=%0d at=%0d want count=1 at=4", dones, done_at);
    end
    total++;
    if (rvs !== 0) begin
      bad++;
      $display("FAIL wr_rvalid got pulses=%0d want=0", rvs);
    end
    d_we = 1'b0;
  endtask

  task automatic test_unaligned();
    logic [9:0]  addrs[4];
    logic [31:0] datas[4];
    int na, nd, dones;
    ready_lat = 2;
    na = 0; nd = 0; dones = 0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h047;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      d_req = 1'b0;
      if (mem_en && mem_ready && na < 4) begin addrs[na] = mem_addr; na++; end
      if (d_rvalid && nd < 4) begin datas[nd] = d_rdata; nd++; end
      if (d_done) dones++;
    end
    total++;
    if (na !== 4 || nd !== 4 || dones !== 1) begin
      bad++;
      $display("FAIL ua_counts got beats=%0d rvalid=%0d done=%0d want 4 4 1", na, nd, dones);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= na || k >= nd ||
          {addrs[k], datas[k]} !== {10'h044 + 10'(k), model(10'h044 + 10'(k))}) begin
        bad++;
        $display("FAIL ua_beat k=%0d got addr=%h data=%h want addr=%h data=%h",
                 k, addrs[k], datas[k], 10'h044 + 10'(k), model(10'h044 + 10'(k)));
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    ready_lat = 1;
    dones = 0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 10'h100;
    @(negedge clk);
    i_req = 1'b0;
    repeat (2) @(negedge clk);  // now on beat 2
    total++;
    if (mem_addr !== 10'h102) begin
      bad++;
      $display("FAIL rm_beat2 got addr=%h want=102", mem_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({i_gnt, i_rvalid, i_done, busy, mem_en, mem_addr, i_rdata} !== 47'h0) begin
      bad++;
      $display("FAIL rm_clear got gnt=%b rv=%b done=%b busy=%b en=%b addr=%h rdata=%h want 0",
               i_gnt, i_rvalid, i_done, busy, mem_en, mem_addr, i_rdata);
    end
    @(negedge clk);
    if (i_done) dones++;
    reset = 1'b1;
    i_req = 1'b1; i_addr = 10'h104;
    @(negedge clk);
    i_req = 1'b0;
    total++;
    if ({i_gnt, mem_en, mem_addr} !== {2'b11, 10'h104}) begin
      bad++;
      $display("FAIL rm_restart got gnt=%b en=%b addr=%h want 1 1 104", i_gnt, mem_en, mem_addr);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (i_done) dones++;
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL rm_done got count=%0d want=1", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] seq;
    int n, hot_err;
    logic prev_i, prev_d;
    bit idle_seen;
    do_reset();
    ready_lat = 1;
    seq = '0; n = 0; hot_err = 0; prev_i = 1'b0; prev_d = 1'b0; idle_seen = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 10'h200; d_addr = 10'h300;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (i_gnt && d_gnt) hot_err++;
      if (n < 6 && i_gnt && !prev_i) begin seq[n] = 1'b0; n++; end
      if (n < 6 && d_gnt && !prev_d) begin seq[n] = 1'b1; n++; end
      prev_i = i_gnt; prev_d = d_gnt;
      if (n == 6) begin i_req = 1'b0; d_req = 1'b0; end
      if (n == 6 && !busy) begin idle_seen = 1'b1; break; end
    end
    total++;
    if (n !== 6 || seq !== 6'b101010 || !idle_seen) begin
      bad++;
      $display("FAIL rr_seq got n=%0d seq=%b idle=%b want n=6 seq=101010 idle=1",
               n, seq, idle_seen);
    end
    total++;
    if (hot_err !== 0) begin
      bad++;
      $display("FAIL rr_onehot got overlaps=%0d want=0", hot_err);
    end
`ifdef MAIN_MEM_ARB_PERF_EN
    total++;
    if ({perf_i_grants, perf_d_grants} !== {16'd3, 16'd3}) begin
      bad++;
      $display("FAIL perf_grants got i=%0d d=%0d want 3 3", perf_i_grants, perf_d_grants);
    end
`endif
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_i_refill();
    test_ignore_ready();
    test_tie();
    test_write_wait();
    test_unaligned();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
